// File: rtl/aes_inv_round_key_stage.sv
// Inverse-cipher AddRoundKey stage: latches the AES-128 expanded key per block and XORs 11 state beats with round keys 10..0.
// Optional build macro AES_EQINV_KEY_EN applies InvMixColumns to round keys 9..1 (equivalent inverse cipher).
module aes_inv_round_key_stage (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [0:1407] expandedKey,
    input  logic          inValid,
    output logic          inReady,
    input  logic [0:127]  stateIn,
    output logic          outValid,
    input  logic          outReady,
    output logic [0:127]  stateOut,
    output logic [3:0]    roundIdx,
    output logic          lastRound,
    output logic          busy
);

`ifdef AES_EQINV_KEY_EN
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9/b/d/e are built from the x2/x4/x8 doubling chain.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] s  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            s[i]  = col[31-8*i -: 8];
            x2[i] = xtime(s[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ s[i];
            mb[i] = x8[i] ^ x2[i] ^ s[i];
            md[i] = x8[i] ^ x4[i] ^ s[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        res[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        res[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        res[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        res[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        return res;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] st);
        logic [127:0] res;
        for (int c = 0; c < 4; c++) begin
            res[127-32*c -: 32] = inv_mix_column(st[127-32*c -: 32]);
        end
        return res;
    endfunction
`endif

    logic [0:1407] key_q, key_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          out_valid_q, out_valid_d;
    logic [0:127]  state_out_q, state_out_d;
    logic [3:0]    round_idx_q, round_idx_d;
    logic          last_round_q, last_round_d;

    logic [127:0]  rk_raw;
    logic [127:0]  rk_sel;
    logic          in_ready;
    logic          accept;
    logic          xfer;

    always_comb begin
        rk_raw = '0;
        case (cnt_q)
            4'd0:    rk_raw = key_q[0*128 +: 128];
            4'd1:    rk_raw = key_q[1*128 +: 128];
            4'd2:    rk_raw = key_q[2*128 +: 128];
            4'd3:    rk_raw = key_q[3*128 +: 128];
            4'd4:    rk_raw = key_q[4*128 +: 128];
            4'd5:    rk_raw = key_q[5*128 +: 128];
            4'd6:    rk_raw = key_q[6*128 +: 128];
            4'd7:    rk_raw = key_q[7*128 +: 128];
            4'd8:    rk_raw = key_q[8*128 +: 128];
            4'd9:    rk_raw = key_q[9*128 +: 128];
            4'd10:   rk_raw = key_q[10*128 +: 128];
            default: rk_raw = '0;
        endcase
    end

`ifdef AES_EQINV_KEY_EN
    // First and last rounds of the equivalent inverse cipher keep the raw key.
    assign rk_sel = (cnt_q != 4'd0 && cnt_q != 4'd10) ? inv_mix_columns(rk_raw) : rk_raw;
`else
    assign rk_sel = rk_raw;
`endif

    // Single-entry output stage: a beat may enter whenever the slot is empty or draining.
    assign in_ready = busy_q && (!out_valid_q || outReady);
    assign accept   = inValid && in_ready;
    assign xfer     = out_valid_q && outReady;

    always_comb begin
        key_d        = key_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        out_valid_d  = out_valid_q;
        state_out_d  = state_out_q;
        round_idx_d  = round_idx_q;
        last_round_d = last_round_q;

        if (start && !busy_q) begin
            key_d  = expandedKey;
            cnt_d  = 4'd10;
            busy_d = 1'b1;
        end

        if (accept) begin
            state_out_d  = stateIn ^ rk_sel;
            round_idx_d  = cnt_q;
            last_round_d = (cnt_q == 4'd0);
            out_valid_d  = 1'b1;
            if (cnt_q == 4'd0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q        <= '0;
            cnt_q        <= 4'd10;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            state_out_q  <= '0;
            round_idx_q  <= 4'd0;
            last_round_q <= 1'b0;
        end else begin
            key_q        <= key_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            state_out_q  <= state_out_d;
            round_idx_q  <= round_idx_d;
            last_round_q <= last_round_d;
        end
    end

    assign inReady   = in_ready;
    assign outValid  = out_valid_q;
    assign stateOut  = state_out_q;
    assign roundIdx  = round_idx_q;
    assign lastRound = last_round_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_round_key_stage.sv
// Bench for aes_inv_round_key_stage: key-expansion based reference model, per-cycle scoreboard and FIPS-197 C.1 anchors.
module tb_aes_inv_round_key_stage;

    logic          clk;
    logic          rst;
    logic          start;
    logic [0:1407] expandedKey;
    logic          inValid;
    logic          inReady;
    logic [0:127]  stateIn;
    logic          outValid;
    logic          outReady;
    logic [0:127]  stateOut;
    logic [3:0]    roundIdx;
    logic          lastRound;
    logic          busy;

    aes_inv_round_key_stage dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .expandedKey(expandedKey),
        .inValid    (inValid),
        .inReady    (inReady),
        .stateIn    (stateIn),
        .outValid   (outValid),
        .outReady   (outReady),
        .stateOut   (stateOut),
        .roundIdx   (roundIdx),
        .lastRound  (lastRound),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:1407] expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1407] ek;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ek[32*i +: 32] = w[i];
        return ek;
    endfunction

    function automatic logic [7:0] imc_coef(input int idx);
        case (idx)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0]   acc;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(imc_coef((j - r + 4) % 4), x[127-8*(4*c+j) -: 8]);
                y[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] model_rk(input logic [0:1407] k, input int r);
        logic [127:0] x;
        x = k[128*r +: 128];
`ifdef AES_EQINV_KEY_EN
        if (r >= 1 && r <= 9) x = inv_mix(x);
`endif
        return x;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [127:0] st;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    exp_t          q[$];
    logic          busy_m = 1'b0;
    int            beat_m = 0;
    logic [0:1407] key_m  = '0;

    initial begin
        logic exp_rdy;
        logic b0;
        int   r;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                busy_m = 1'b0;
                beat_m = 0;
                chk("rst_outValid", 128'(outValid), 128'(0));
                chk("rst_inReady", 128'(inReady), 128'(0));
                chk("rst_busy", 128'(busy), 128'(0));
                chk("rst_stateOut", 128'(stateOut), 128'(0));
                chk("rst_roundIdx", 128'(roundIdx), 128'(0));
                chk("rst_lastRound", 128'(lastRound), 128'(0));
            end else begin
                exp_rdy = busy_m && (q.size() == 0 || outReady);
                chk("busy", 128'(busy), 128'(busy_m));
                chk("outValid", 128'(outValid), 128'(q.size() != 0));
                chk("inReady", 128'(inReady), 128'(exp_rdy));
                if (q.size() != 0) begin
                    chk("stateOut", 128'(stateOut), q[0].st);
                    chk("roundIdx", 128'(roundIdx), 128'(q[0].idx));
                    chk("lastRound", 128'(lastRound), 128'(q[0].last));
                    if (outReady) void'(q.pop_front());
                end
                b0 = busy_m;
                if (inValid && exp_rdy) begin
                    r      = 10 - beat_m;
                    e.st   = 128'(stateIn) ^ model_rk(key_m, r);
                    e.idx  = 4'(r);
                    e.last = (r == 0);
                    q.push_back(e);
                    beat_m++;
                    if (beat_m == 11) busy_m = 1'b0;
                end
                if (start && !b0) begin
                    busy_m = 1'b1;
                    beat_m = 0;
                    key_m  = expandedKey;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic rdy_mode = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) outReady = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [0:1407] k);
        start       = 1'b1;
        expandedKey = k;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] s, input int gap);
        logic acc;
        int   n;
        repeat (gap) tick();
        inValid = 1'b1;
        stateIn = s;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc = inReady;
            tick();
            n++;
        end
        chk("beat_accept_timeout", 128'(acc), 128'(1));
        inValid = 1'b0;
        stateIn = rnd128();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:1407] ek;
        logic [0:127]  held;
        logic [127:0]  exp9;
        rst         = 1'b1;
        start       = 1'b0;
        expandedKey = '0;
        inValid     = 1'b0;
        stateIn     = '0;
        outReady    = 1'b0;
        tick();
        tick();
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_stateOut", 128'(stateOut), 128'(0));
        rst = 1'b0;
        tick();
        chk("idle_inReady", 128'(inReady), 128'(0));

        // FIPS-197 C.1 block with back-pressure after the third beat
        outReady = 1'b1;
        ek = expand(128'h000102030405060708090a0b0c0d0e0f);
        chk("model_rk10", model_rk(ek, 10) ^ 128'h0, ek[1280 +: 128]);
        do_start(ek);
        chk("start_inReady", 128'(inReady), 128'(1));
        send_beat(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);
        chk("c1_first_state", 128'(stateOut), 128'h7ad5fda789ef4e272bca100b3d9ff59f);
        chk("c1_first_idx", 128'(roundIdx), 128'(10));
        chk("c1_first_last", 128'(lastRound), 128'(0));
        send_beat(128'h0, 0);
        exp9 = 128'h549932d1f08557681093ed9cbe2c974e;
`ifdef AES_EQINV_KEY_EN
        exp9 = inv_mix(exp9);
`endif
        chk("rk9_zero_state", 128'(stateOut), exp9);
        chk("rk9_idx", 128'(roundIdx), 128'(9));
        send_beat(rnd128(), 0);
        outReady = 1'b0;
        inValid  = 1'b1;
        stateIn  = rnd128();
        held     = stateOut;
        repeat (5) begin
            @(negedge clk);
            chk("bp_inReady", 128'(inReady), 128'(0));
            chk("bp_stateOut", 128'(stateOut), 128'(held));
            tick();
        end
        outReady = 1'b1;
        send_beat(128'(stateIn), 0);
        for (int b = 4; b < 10; b++) send_beat(rnd128(), 0);
        send_beat(128'h00102030405060708090a0b0c0d0e0f0, 0);
        chk("c1_last_state", 128'(stateOut), 128'h00112233445566778899aabbccddeeff);
        chk("c1_last_idx", 128'(roundIdx), 128'(0));
        chk("c1_last_flag", 128'(lastRound), 128'(1));
        chk("c1_busy_clear", 128'(busy), 128'(0));
        inValid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("extra_beat_inReady", 128'(inReady), 128'(0));
            tick();
        end
        inValid = 1'b0;

        // start while busy is ignored; key input changes mid-block
        rdy_mode = 1'b1;
        do_start(expand(rnd128()));
        for (int b = 0; b < 4; b++) send_beat(rnd128(), $urandom_range(0, 2));
        do_start(expand(rnd128()));
        chk("ignored_start_busy", 128'(busy), 128'(1));
        for (int b = 4; b < 11; b++) send_beat(rnd128(), $urandom_range(0, 2));
        rdy_mode = 1'b0;
        outReady = 1'b1;
        repeat (3) tick();

        // reset in the middle of a block
        do_start(expand(rnd128()));
        for (int b = 0; b < 6; b++) send_beat(rnd128(), 0);
        rst = 1'b1;
        #1;
        chk("midrst_outValid", 128'(outValid), 128'(0));
        chk("midrst_stateOut", 128'(stateOut), 128'(0));
        chk("midrst_roundIdx", 128'(roundIdx), 128'(0));
        chk("midrst_lastRound", 128'(lastRound), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_inReady", 128'(inReady), 128'(0));
        tick();
        rst = 1'b0;
        tick();
        do_start(expand(rnd128()));
        send_beat(rnd128(), 0);
        chk("post_rst_idx", 128'(roundIdx), 128'(10));
        for (int b = 1; b < 11; b++) send_beat(rnd128(), 0);

        // randomized blocks with random back-pressure, gaps and stray starts
        rdy_mode = 1'b1;
        repeat (25) begin
            if ($urandom_range(0, 1) == 1) tick();
            do_start(expand(rnd128()));
            for (int b = 0; b < 11; b++) begin
                if ($urandom_range(0, 7) == 0) do_start(expand(rnd128()));
                send_beat(rnd128(), $urandom_range(0, 2));
            end
        end
        rdy_mode = 1'b0;
        outReady = 1'b1;
        repeat (5) tick();
        chk("drain_outValid", 128'(outValid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
